ps2_scan_receiver: RTL and testbench
====================================

PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL have parameter FILTER_BITS, default 8: consecutive equal ps2c samples required before the filtered clock changes level.
REQ-002 SHALL have parameter TIMEOUT, default 100000: clk cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; the single clock domain.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ps2d  input  1  raw PS/2 data line, asynchronous to clk.
REQ-006 SHALL have port ps2c  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ready  output  1  one-cycle pulse marking a new decoded key.
REQ-008 SHALL have port key  output  8  scan code of the last decoded key.
REQ-009 SHALL have port brk  output  1  last key was preceded by the F0 break prefix (key release).
REQ-010 SHALL have port ext  output  1  last key was preceded by the E0 extended prefix.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on any framing, parity or timeout error.

Function
REQ-012 SHALL pass ps2c and ps2d through 2-flop synchronizers before any use.
REQ-013 SHALL drive filtered clock low only after FILTER_BITS synchronized lows, high only after FILTER_BITS highs, and hold it otherwise.
REQ-014 SHALL define a sample event as the cycle in which the filtered clock goes from 1 to 0; ps2d is sampled on that cycle.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY and STOP.
REQ-016 IDLE: sample 0 -> DATA with bit count 0; sample 1 -> frame_err pulse, remain IDLE.
REQ-017 DATA: each sample shifts in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: sample is the parity bit; frame is valid only when the 8 data bits plus parity contain an odd number of ones; -> STOP.
REQ-019 STOP: sample must be 1 and parity valid, otherwise frame_err pulse; -> IDLE in both cases.
REQ-020 Valid byte 0xE0 SHALL set ext_pending, 0xF0 SHALL set brk_pending, and neither SHALL pulse ready.
REQ-021 Any other valid byte SHALL load key, brk<=brk_pending and ext<=ext_pending, pulse ready, and clear both pending flags.
REQ-022 ready SHALL assert in the cycle after the stop-bit sample event; key, brk and ext SHALL hold until the next ready.
REQ-023 Outside IDLE, a counter SHALL count cycles since the last sample event; at TIMEOUT the FSM SHALL return to IDLE, pulse frame_err and discard the partial byte.
REQ-024 A sample event and a timeout in the same cycle SHALL be resolved as a sample event, and the counter SHALL restart.
REQ-025 Every frame_err SHALL clear both pending flags; ready and frame_err SHALL never assert in the same cycle.

Reset
REQ-026 On reset: state IDLE, counters 0, pending flags 0, and ready, key, brk, ext and frame_err all 0.
REQ-027 On reset, synchronizer and filter registers SHALL be set to 1 (idle bus), so no sample event follows reset release.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without a ready or frame_err pulse.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state enum and the constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
REQ-030 Synchronizer, glitch filter and falling-edge detect SHALL form sub-module ps2_edge_filter, instantiated for ps2c; ps2d SHALL use the synchronizer only.

Verification
REQ-031 Frame 0x1C with parity 0 and stop 1 -> one ready pulse one cycle after the stop sample; key=0x1C, brk=0, ext=0.
REQ-032 Frames F0 then 1C -> exactly one ready pulse; key=0x1C, brk=1, ext=0.
REQ-033 Frames E0, F0, 75 -> one ready pulse; key=0x75, brk=1, ext=1.
REQ-034 Frame 0x1C with parity 1 -> frame_err pulse and no ready; the following good frame 0x1C decodes normally.
REQ-035 3-cycle low glitch on ps2c in IDLE -> no sample event; clock stopped after 5 data bits -> frame_err exactly TIMEOUT cycles after the last sample, then the next frame decodes correctly.
REQ-036 Reset asserted after bit 4 -> all outputs 0 and no pulse; the next full frame 0x29 decodes to key=0x29.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver.
// Holds the frame FSM state type and the two scan-code prefix bytes.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

endpackage

// File: rtl/ps2_edge_filter.sv
// Conditions the raw PS/2 clock line: 2-flop synchronizer, glitch filter and
// falling-edge detector.
//   clk_i    system clock
//   reset_i  asynchronous active-high reset
//   ps2c_i   raw PS/2 clock, asynchronous to clk_i
//   fall_o   high for the one cycle in which the filtered clock goes 1 -> 0
module ps2_edge_filter #(
    parameter int unsigned FILTER_BITS = 8  // must be >= 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ps2c_i,
    output logic fall_o
);

    logic                   meta_q;
    logic                   sync_q;
    logic [FILTER_BITS-1:0] hist_q;
    logic                   filt_q;
    logic                   filt_d;

    // Everything resets to 1 so an idle bus produces no edge on reset release.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            meta_q <= ps2c_i;
            sync_q <= meta_q;
            hist_q <= {hist_q[FILTER_BITS-2:0], sync_q};
            filt_q <= filt_d;
        end
    end

    // The filtered level only moves once the whole history window agrees.
    always_comb begin
        filt_d = filt_q;
        if (hist_q == '0) begin
            filt_d = 1'b0;
        end else if (hist_q == '1) begin
            filt_d = 1'b1;
        end
    end

    assign fall_o = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: decodes 11-bit frames into scan codes and folds the
// E0 (extended) and F0 (break) prefixes into flags on the following key.
//   clk        system clock
//   reset      asynchronous active-high reset
//   ps2d/ps2c  raw PS/2 data and clock lines, asynchronous to clk
//   ready      one-cycle pulse: key/brk/ext were just updated
//   key        last decoded scan code
//   brk, ext   last key carried the F0 / E0 prefix
//   frame_err  one-cycle pulse on start, parity, stop or timeout error
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_BITS = 8,
    parameter int unsigned TIMEOUT     = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       ready,
    output logic [7:0] key,
    output logic       brk,
    output logic       ext,
    output logic       frame_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic            fall;
    logic            ps2d_meta_q;
    logic            ps2d_sync_q;
    ps2_state_e      state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_ok_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            ext_pend_q;
    logic            brk_pend_q;
    logic            ready_q;
    logic            frame_err_q;
    logic [7:0]      key_q;
    logic            brk_q;
    logic            ext_q;

    ps2_edge_filter #(
        .FILTER_BITS(FILTER_BITS)
    ) u_clk_filter (
        .clk_i  (clk),
        .reset_i(reset),
        .ps2c_i (ps2c),
        .fall_o (fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2d_meta_q <= 1'b1;
            ps2d_sync_q <= 1'b1;
        end else begin
            ps2d_meta_q <= ps2d;
            ps2d_sync_q <= ps2d_meta_q;
        end
    end

    // tmo_cnt_q holds the number of cycles since the last sample event, so the
    // timeout pulse lands exactly TIMEOUT cycles after that event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            key_q       <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (fall) begin
                // A sample event wins over a coincident timeout.
                tmo_cnt_q <= TmoW'(1);
                unique case (state_q)
                    StIdle: begin
                        if (!ps2d_sync_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            brk_pend_q  <= 1'b0;
                            tmo_cnt_q   <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {ps2d_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        par_ok_q <= ^{shift_q, ps2d_sync_q};
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q   <= StIdle;
                        tmo_cnt_q <= '0;
                        if (ps2d_sync_q && par_ok_q) begin
                            if (shift_q == PS2_PREFIX_EXT) begin
                                ext_pend_q <= 1'b1;
                            end else if (shift_q == PS2_PREFIX_BRK) begin
                                brk_pend_q <= 1'b1;
                            end else begin
                                key_q      <= shift_q;
                                brk_q      <= brk_pend_q;
                                ext_q      <= ext_pend_q;
                                ready_q    <= 1'b1;
                                ext_pend_q <= 1'b0;
                                brk_pend_q <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            brk_pend_q  <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q != StIdle) begin
                if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                    state_q     <= StIdle;
                    tmo_cnt_q   <= '0;
                    frame_err_q <= 1'b1;
                    ext_pend_q  <= 1'b0;
                    brk_pend_q  <= 1'b0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
                end
            end
        end
    end

    assign ready     = ready_q;
    assign frame_err = frame_err_q;
    assign key       = key_q;
    assign brk       = brk_q;
    assign ext       = ext_q;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;

    localparam int FB   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;

    logic       clk;
    logic       reset;
    logic       ps2d;
    logic       ps2c;
    logic       ready;
    logic [7:0] key;
    logic       brk;
    logic       ext;
    logic       frame_err;

    ps2_scan_receiver #(
        .FILTER_BITS(FB),
        .TIMEOUT    (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2d     (ps2d),
        .ps2c     (ps2c),
        .ready    (ready),
        .key      (key),
        .brk      (brk),
        .ext      (ext),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         flip;
        bit         stop;
        bit         e_rdy;
        bit         e_err;
        logic [7:0] e_key;
        bit         e_brk;
        bit         e_ext;
    } vec_t;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int ready_cnt  = 0;
    int err_cnt    = 0;
    int both_cnt   = 0;
    int ready_cyc  = 0;
    int err_cyc    = 0;
    int last_fall  = 0;

    // Behavioural model state: pending prefixes and last reported key.
    bit         m_pe, m_pb, m_kb, m_ke;
    logic [7:0] m_key;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready) begin
            ready_cnt <= ready_cnt + 1;
            ready_cyc <= cyc;
        end
        if (frame_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (ready && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input bit b);
        ps2d = b;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(posedge clk);
        #1 ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ flip);
        send_bit(stop);
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag);
        int r0, e0;
        r0 = ready_cnt;
        e0 = err_cnt;
        send_frame(v.d, v.flip, v.stop);
        check({tag, " ready_count"}, ready_cnt - r0, int'(v.e_rdy));
        check({tag, " err_count"}, err_cnt - e0, int'(v.e_err));
        if (v.e_rdy) check({tag, " ready_latency"}, ready_cyc - last_fall, 3 + FB);
        if (v.e_err) check({tag, " err_latency"}, err_cyc - last_fall, 3 + FB);
        check({tag, " key"}, int'(key), int'(v.e_key));
        check({tag, " brk"}, int'(brk), int'(v.e_brk));
        check({tag, " ext"}, int'(ext), int'(v.e_ext));
    endtask

    task automatic model_reset();
        m_pe = 0; m_pb = 0; m_kb = 0; m_ke = 0; m_key = 8'h00;
    endtask

    // Frame-level decode from the protocol rules: odd total ones, stop = 1.
    task automatic model(input logic [7:0] d, input bit flip, input bit stop, output vec_t v);
        int  ones;
        bit  par, valid;
        ones  = $countones(d);
        par   = ((ones % 2) == 0) ^ flip;
        valid = stop && (((ones + int'(par)) % 2) == 1);
        v.d = d; v.flip = flip; v.stop = stop; v.e_rdy = 0; v.e_err = 0;
        if (!valid) begin
            v.e_err = 1; m_pe = 0; m_pb = 0;
        end else if (d == 8'hE0) begin
            m_pe = 1;
        end else if (d == 8'hF0) begin
            m_pb = 1;
        end else begin
            v.e_rdy = 1; m_key = d; m_kb = m_pb; m_ke = m_pe; m_pe = 0; m_pb = 0;
        end
        v.e_key = m_key; v.e_brk = m_kb; v.e_ext = m_ke;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", int'(ready), 0);
        check("reset frame_err", int'(frame_err), 0);
        check("reset key", int'(key), 0);
        check("reset brk", int'(brk), 0);
        check("reset ext", int'(ext), 0);
        reset = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];

    initial begin
        int r0, e0, n;
        vec_t v;
        reset = 1'b1;
        ps2c  = 1'b1;
        ps2d  = 1'b1;

        tbl[0]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[1]  = '{8'hF0, 0, 1, 0, 0, 8'h1C, 0, 0};
        tbl[2]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 1, 0};
        tbl[3]  = '{8'hE0, 0, 1, 0, 0, 8'h1C, 1, 0};
        tbl[4]  = '{8'hF0, 0, 1, 0, 0, 8'h1C, 1, 0};
        tbl[5]  = '{8'h75, 0, 1, 1, 0, 8'h75, 1, 1};
        tbl[6]  = '{8'h1C, 1, 1, 0, 1, 8'h75, 1, 1};
        tbl[7]  = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        tbl[8]  = '{8'hE0, 0, 1, 0, 0, 8'h1C, 0, 0};
        tbl[9]  = '{8'h29, 0, 0, 0, 1, 8'h1C, 0, 0};
        tbl[10] = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0};
        tbl[11] = '{8'hF0, 0, 1, 0, 0, 8'h29, 0, 0};
        tbl[12] = '{8'h1C, 1, 1, 0, 1, 8'h29, 0, 0};
        tbl[13] = '{8'h74, 0, 1, 1, 0, 8'h74, 0, 0};

        do_reset();
        for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Start bit read as 1 in IDLE.
        e0 = err_cnt;
        send_bit(1'b1);
        repeat (HALF) @(posedge clk);
        #1;
        check("bad_start err_count", err_cnt - e0, 1);
        check("bad_start err_latency", err_cyc - last_fall, 3 + FB);

        // Short low glitch on ps2c while idle must not create a sample event.
        r0 = ready_cnt;
        e0 = err_cnt;
        ps2d = 1'b1;
        @(posedge clk);
        #1 ps2c = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch err_count", err_cnt - e0, 0);
        check("glitch ready_count", ready_cnt - r0, 0);

        // F0 prefix, then a frame stalled after 5 data bits: timeout clears it.
        v = '{8'hF0, 0, 1, 0, 0, 8'h74, 0, 0};
        apply(v, "pre_tmo");
        r0 = ready_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        n = 0;
        while (err_cnt == e0 && n < 2 * TO + 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("timeout err_count", err_cnt - e0, 1);
        check("timeout err_latency", err_cyc - last_fall, 2 + FB + TO);
        check("timeout ready_count", ready_cnt - r0, 0);
        v = '{8'h1C, 0, 1, 1, 0, 8'h1C, 0, 0};
        apply(v, "post_tmo");

        // Reset after the 4th data bit of a frame.
        r0 = ready_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        do_reset();
        check("midreset ready_count", ready_cnt - r0, 0);
        check("midreset err_count", err_cnt - e0, 0);
        v = '{8'h29, 0, 1, 1, 0, 8'h29, 0, 0};
        apply(v, "post_reset");

        // Randomized frames against the behavioural model.
        do_reset();
        model_reset();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            bit flip, stop;
            case ($urandom_range(0, 3))
                0:       d = 8'hE0;
                1:       d = 8'hF0;
                default: d = 8'($urandom_range(0, 255));
            endcase
            flip = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 7) != 0);
            model(d, flip, stop, v);
            apply(v, $sformatf("rnd%0d_%02h", i, d));
        end

        check("ready_err_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
